// File: rtl/game_pkg.sv
// Shared game-level types, screen geometry and small datapath helpers.
package game_pkg;

  typedef enum logic [1:0] {PRES_LIFE, PRES_ROPE, PRES_SPEED, PRES_IMMORTAL} present_t;

  typedef enum logic [1:0] {ST_IDLE, ST_FALLING, ST_LANDED} spawn_state_t;

  localparam logic [10:0] SCREEN_W  = 11'd640;
  localparam logic [10:0] SCREEN_H  = 11'd480;
  localparam logic [10:0] SPRITE_WH = 11'd32;

  function automatic logic [10:0] clamp11(input logic [10:0] v, input logic [10:0] hi);
    clamp11 = (v > hi) ? hi : v;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11), right-shifting.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] q
);

  logic [15:0] q_d;
  logic [15:0] q_q;

  // Next value: feedback from taps enters at the MSB.
  always_comb begin
    q_d = {q_q[0] ^ q_q[2] ^ q_q[3] ^ q_q[5], q_q[15:1]};
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q <= SEED;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/present_spawner.sv
// Bonus present spawner: spawns one present at the popped ball, drops it to
// the floor, times its life there and clears it on collection or play end.
module present_spawner
  import game_pkg::*;
#(
  parameter logic [10:0] FLOOR_Y   = 11'd440,
  parameter logic [10:0] X_MAX     = 11'd607,
  parameter logic [10:0] FALL_STEP = 11'd2,
  parameter logic [2:0]  LIFETIME  = 3'd5,
  parameter logic [2:0]  BLINK_AT  = 3'd2,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startOfFrame,
  input  logic        secClk,
  input  logic        playmodeEnable,
  input  logic        presentDrop,
  input  logic [10:0] dropX,
  input  logic [10:0] dropY,
  input  logic        col_present,
  output logic [1:0]  presentChance,
  output logic [1:0]  presentType,
  output logic        presentActive,
  output logic [10:0] presentX,
  output logic [10:0] presentY,
  output logic        presentBlink
);

  logic [15:0]  lfsr_q;
  logic [11:0]  lfsr_unused;
  spawn_state_t state_q, state_d;
  present_t     type_q, type_d;
  logic [10:0]  x_q, x_d, y_q, y_d;
  logic [2:0]   timer_q, timer_d;
  logic [1:0]   chance_q, chance_d;
  logic         blink_q, blink_d;
  logic [11:0]  y_step;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk  (clk),
    .reset(reset),
    .q    (lfsr_q)
  );

  assign lfsr_unused = lfsr_q[15:4];

  // Next-state and datapath; priority is play end, collection, spawn, motion.
  always_comb begin
    state_d  = state_q;
    type_d   = type_q;
    x_d      = x_q;
    y_d      = y_q;
    timer_d  = timer_q;
    chance_d = lfsr_q[1:0];
    y_step   = {1'b0, y_q} + {1'b0, FALL_STEP};
    if (!playmodeEnable) begin
      state_d = ST_IDLE;
    end else if (col_present && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (presentDrop) begin
            state_d = ST_FALLING;
            x_d     = clamp11(dropX, X_MAX);
            y_d     = clamp11(dropY, FLOOR_Y);
            type_d  = present_t'(lfsr_q[3:2]);
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_FALLING: begin
          if (startOfFrame) begin
            if (y_step >= {1'b0, FLOOR_Y}) begin
              y_d     = FLOOR_Y;
              timer_d = LIFETIME;
              state_d = ST_LANDED;
            end else begin
              y_d = y_step[10:0];
            end
          end else begin
            y_d = y_q;
          end
        end
        ST_LANDED: begin
          if (secClk) begin
            if (timer_q == 3'd0) begin
              state_d = ST_IDLE;
            end else begin
              timer_d = timer_q - 3'd1;
            end
          end else begin
            timer_d = timer_q;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
    blink_d = (state_d == ST_LANDED) && (timer_d <= BLINK_AT);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      type_q   <= PRES_LIFE;
      x_q      <= 11'd0;
      y_q      <= 11'd0;
      timer_q  <= 3'd0;
      chance_q <= LFSR_SEED[1:0];
      blink_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      type_q   <= type_d;
      x_q      <= x_d;
      y_q      <= y_d;
      timer_q  <= timer_d;
      chance_q <= chance_d;
      blink_q  <= blink_d;
    end
  end

  assign presentChance = chance_q;
  assign presentType   = type_q;
  assign presentActive = (state_q != ST_IDLE);
  assign presentX      = x_q;
  assign presentY      = y_q;
  assign presentBlink  = blink_q;

endmodule

// File: tb/tb_present_spawner.sv
// Randomized + directed bench for present_spawner; a behavioural model
// queues per-cycle expectations and a negedge monitor compares them.
module tb_present_spawner;

  logic        clk = 1'b0;
  logic        reset;
  logic        sof, sec, pm, drop, col;
  logic [10:0] dx, dy;
  logic [1:0]  chance, ptype;
  logic        active, blink;
  logic [10:0] px, py;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int active;
    int x;
    int y;
    int ptype;
    int chance;
    int blink;
  } exp_t;

  exp_t exp_q[$];

  // reference model state
  logic [15:0] m_lfsr;
  int m_active, m_falling, m_x, m_y, m_timer, m_type, m_chance;

  present_spawner dut (
    .clk           (clk),
    .reset         (reset),
    .startOfFrame  (sof),
    .secClk        (sec),
    .playmodeEnable(pm),
    .presentDrop   (drop),
    .dropX         (dx),
    .dropY         (dy),
    .col_present   (col),
    .presentChance (chance),
    .presentType   (ptype),
    .presentActive (active),
    .presentX      (px),
    .presentY      (py),
    .presentBlink  (blink)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] next_lfsr(input logic [15:0] v);
    next_lfsr = {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // Reference model: one update per clock edge, expectation queued.
  initial begin
    logic [15:0] cur;
    exp_t e;
    forever begin
      @(posedge clk);
      if (reset) begin
        m_lfsr = 16'hACE1;
        m_chance = int'(m_lfsr[1:0]);
        m_active = 0; m_falling = 0; m_x = 0; m_y = 0; m_timer = 0; m_type = 0;
      end else begin
        cur = m_lfsr;
        m_chance = int'(cur[1:0]);
        m_lfsr = next_lfsr(cur);
        if (!pm) begin
          m_active = 0;
        end else if (col && m_active != 0) begin
          m_active = 0;
        end else if (m_active == 0) begin
          if (drop) begin
            m_active = 1; m_falling = 1;
            m_x = (dx > 607) ? 607 : int'(dx);
            m_y = (dy > 440) ? 440 : int'(dy);
            m_type = int'(cur[3:2]);
          end
        end else if (m_falling != 0) begin
          if (sof) begin
            if (m_y + 2 >= 440) begin
              m_y = 440; m_falling = 0; m_timer = 5;
            end else begin
              m_y = m_y + 2;
            end
          end
        end else if (sec) begin
          if (m_timer == 0) m_active = 0;
          else m_timer = m_timer - 1;
        end
      end
      e.active = m_active; e.x = m_x; e.y = m_y; e.ptype = m_type; e.chance = m_chance;
      e.blink = (m_active != 0 && m_falling == 0 && m_timer <= 2) ? 1 : 0;
      exp_q.push_back(e);
    end
  end

  // Monitor: compares DUT outputs against the oldest queued expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        chk("mon_active", int'(active), exp_q[0].active);
        chk("mon_x", int'(px), exp_q[0].x);
        chk("mon_y", int'(py), exp_q[0].y);
        chk("mon_type", int'(ptype), exp_q[0].ptype);
        chk("mon_chance", int'(chance), exp_q[0].chance);
        chk("mon_blink", int'(blink), exp_q[0].blink);
        void'(exp_q.pop_front());
      end
    end
  end

  // One clock of stimulus; pulses are cleared afterwards.
  task automatic step(input logic s, input logic c, input logic d, input logic co,
                      input logic [10:0] x, input logic [10:0] y);
    sof = s; sec = c; drop = d; col = co; dx = x; dy = y;
    @(negedge clk); #2;
    sof = 1'b0; sec = 1'b0; drop = 1'b0; col = 1'b0;
  endtask

  initial begin
    logic [1:0] typ;
    reset = 1'b1; pm = 1'b1; sof = 1'b0; sec = 1'b0; drop = 1'b0; col = 1'b0;
    dx = 11'd0; dy = 11'd0;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_active", int'(active), 0);
    chk("rst_chance", int'(chance), 1);
    chk("rst_xy", int'(px) + int'(py), 0);
    reset = 1'b0;

    // spawn with clamped X, then fall to the floor
    step(1'b0, 1'b0, 1'b1, 1'b0, 11'd700, 11'd100);
    chk("spawn_x", int'(px), 607);
    chk("spawn_y", int'(py), 100);
    for (int f = 1; f <= 200; f++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 11'd0, 11'd0);
      if (f == 169) chk("y_f169", int'(py), 438);
      if (f == 170) chk("y_f170", int'(py), 440);
    end
    chk("landed_active", int'(active), 1);

    // expire after six seconds, blinking from the third
    for (int s = 1; s <= 6; s++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 11'd0, 11'd0);
      chk("exp_blink", int'(blink), (s >= 3 && s < 6) ? 1 : 0);
      chk("exp_active", int'(active), (s < 6) ? 1 : 0);
    end

    // collect while falling at Y=200
    step(1'b0, 1'b0, 1'b1, 1'b0, 11'd50, 11'd180);
    repeat (10) step(1'b1, 1'b0, 1'b0, 1'b0, 11'd0, 11'd0);
    chk("col_y", int'(py), 200);
    typ = ptype;
    step(1'b0, 1'b0, 1'b0, 1'b1, 11'd0, 11'd0);
    chk("col_active", int'(active), 0);
    chk("col_type", int'(ptype), int'(typ));
    step(1'b0, 1'b0, 1'b0, 1'b0, 11'd0, 11'd0);
    chk("col_type_hold", int'(ptype), int'(typ));

    // second drop ignored; drop+collision clears
    step(1'b0, 1'b0, 1'b1, 1'b0, 11'd300, 11'd300);
    step(1'b1, 1'b0, 1'b0, 1'b0, 11'd0, 11'd0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 11'd10, 11'd10);
    chk("redrop_x", int'(px), 300);
    chk("redrop_y", int'(py), 302);
    step(1'b0, 1'b0, 1'b1, 1'b1, 11'd10, 11'd10);
    chk("dropcol_active", int'(active), 0);

    // play end while landed; no spawn outside play
    step(1'b0, 1'b0, 1'b1, 1'b0, 11'd20, 11'd450);
    chk("clampy", int'(py), 440);
    step(1'b1, 1'b0, 1'b0, 1'b0, 11'd0, 11'd0);
    pm = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0, 11'd0, 11'd0);
    chk("pmoff_active", int'(active), 0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 11'd5, 11'd5);
    chk("pmoff_nospawn", int'(active), 0);
    pm = 1'b1;

    // asynchronous reset mid-fall
    step(1'b0, 1'b0, 1'b1, 1'b0, 11'd123, 11'd0);
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 11'd0, 11'd0);
    reset = 1'b1;
    #1;
    chk("arst_active", int'(active), 0);
    chk("arst_x", int'(px), 0);
    chk("arst_y", int'(py), 0);
    chk("arst_type", int'(ptype), 0);
    chk("arst_chance", int'(chance), 1);
    @(negedge clk); #2;
    reset = 1'b0;

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      pm = ($urandom_range(0, 31) != 0);
      step(($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 19) == 0), ($urandom_range(0, 39) == 0),
           11'($urandom_range(0, 2047)), 11'($urandom_range(0, 2047)));
    end

    step(1'b0, 1'b0, 1'b0, 1'b0, 11'd0, 11'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
